// File: rtl/char_reader.sv
// Host-side reader for the chargen character source: strobes chargen, checks the
// INITCHAR..LASTCHAR sequence, and buffers characters in a first-word-fall-through FIFO.
module char_reader #(
    parameter logic [7:0]  INITCHAR = "a",
    parameter logic [7:0]  LASTCHAR = "z",
    parameter int unsigned AW       = 3
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          n_en,
    output logic          src_cs_n,
    output logic          src_wr_n,
    input  logic [7:0]    src_port,
    input  logic          n_rd,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          err
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CAPT = 2'd1;
    localparam logic [1:0] ADV  = 2'd2;
    localparam logic [1:0] SETL = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          cs_n_q, cs_n_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          err_q, err_d;
    logic [7:0]    exp_q, exp_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push, pop;

    function automatic logic [7:0] nxt(input logic [7:0] c);
        return (c == LASTCHAR) ? INITCHAR : c + 8'd1;
    endfunction

    // Sequencer, FIFO bookkeeping and sequence checker
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        err_d   = err_q;
        exp_d   = exp_q;

        case (state_q)
            IDLE:    if (!n_en && !full_q) state_d = CAPT;
            CAPT:    state_d = ADV;
            ADV:     state_d = SETL;
            SETL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cs_n_d = (state_d != ADV);

        // Only reachable from IDLE with full low, so a push never meets a full FIFO
        push = (state_q == CAPT);
        pop  = !n_rd && !empty_q;

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);

        // On a match nxt(src_port) equals nxt(exp_q); on a mismatch it resyncs
        if (push) begin
            if (src_port != exp_q) err_d = 1'b1;
            exp_d = nxt(src_port);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            exp_q   <= INITCHAR;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
            exp_q   <= exp_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= src_port;
    end

    assign src_cs_n = cs_n_q;
    assign src_wr_n = 1'b1;
    assign dout     = mem_q[rptr_q];
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_char_reader.sv
// Directed bench for char_reader wired to a small chargen model wrapping a..c.
module tb_char_reader;

    localparam logic [7:0] CH_A = 8'h61;
    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_C = 8'h63;
    localparam logic [7:0] CH_X = 8'h78;

    logic       clk = 1'b0;
    logic       n_rst, n_en, n_rd, force_x;
    logic       src_cs_n, src_wr_n, empty, full, err;
    logic [7:0] src_port, dout, chr;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] dout;
        logic [2:0] count;
        logic       full;
    } pop_vec_t;

    pop_vec_t tbl [4];

    char_reader #(.INITCHAR("a"), .LASTCHAR("c"), .AW(2)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .n_en     (n_en),
        .src_cs_n (src_cs_n),
        .src_wr_n (src_wr_n),
        .src_port (src_port),
        .n_rd     (n_rd),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .err      (err)
    );

    always #5 clk = ~clk;

    // chargen stand-in: one cs pulse advances a->b->c->a
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)         chr <= CH_A;
        else if (!src_cs_n) chr <= (chr == CH_C) ? CH_A : chr + 8'd1;
    end

    assign src_port = force_x ? CH_X : chr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int k;
        logic cs_ok;

        tbl[0] = '{CH_A, 3'd4, 1'b1};
        tbl[1] = '{CH_B, 3'd3, 1'b0};
        tbl[2] = '{CH_C, 3'd2, 1'b0};
        tbl[3] = '{CH_A, 3'd1, 1'b0};

        n_rst = 1'b1; n_en = 1'b1; n_rd = 1'b1; force_x = 1'b0;

        // 1: reset pulse
        #3 n_rst = 1'b0;
        #1;
        check("rst_cs_n",  32'(src_cs_n), 32'd1);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("t1_empty",  32'(empty),    32'd1);
        check("t1_full",   32'(full),     32'd0);
        check("t1_count",  32'(count),    32'd0);
        check("t1_err",    32'(err),      32'd0);
        check("t1_cs_n",   32'(src_cs_n), 32'd1);
        check("t1_wr_n",   32'(src_wr_n), 32'd1);

        // 2: fill to full with no pops
        n_en = 1'b0;
        for (k = 0; k < 200 && full !== 1'b1; k++) @(negedge clk);
        check("t2_full",  32'(full),  32'd1);
        check("t2_count", 32'(count), 32'd4);
        repeat (3) @(negedge clk);
        cs_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (src_cs_n !== 1'b1) cs_ok = 1'b0;
            @(negedge clk);
        end
        check("t2_cs_idle", 32'(cs_ok), 32'd1);

        // 3: drain with fetch disabled
        n_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_dout%0d", i),  32'(dout),  32'(tbl[i].dout));
            check($sformatf("t3_count%0d", i), 32'(count), 32'(tbl[i].count));
            check($sformatf("t3_full%0d", i),  32'(full),  32'(tbl[i].full));
            check($sformatf("t3_empty%0d", i), 32'(empty), 32'd0);
            n_rd = 1'b0;
            @(negedge clk);
            n_rd = 1'b1;
        end
        check("t3_empty", 32'(empty), 32'd1);
        check("t3_count0", 32'(count), 32'd0);
        n_rd = 1'b0;
        @(negedge clk);
        n_rd = 1'b1;
        check("t3_pop_empty_count", 32'(count), 32'd0);
        check("t3_pop_empty_flag",  32'(empty), 32'd1);

        n_en = 1'b0;
        for (k = 0; k < 20 && empty !== 1'b0; k++) @(negedge clk);
        check("t3_refill_b", 32'(dout), 32'(CH_B));
        check("t3_err",      32'(err),  32'd0);

        // 4: corrupt one capture; sitting in ADV right after the b push
        for (k = 0; k < 20 && src_cs_n !== 1'b0; k++) @(negedge clk);
        check("t4_in_adv", 32'(src_cs_n), 32'd0);
        force_x = 1'b1;
        repeat (3) @(negedge clk);
        n_en = 1'b1;
        @(negedge clk);
        force_x = 1'b0;
        check("t4_err_set", 32'(err), 32'd1);
        repeat (4) @(negedge clk);
        check("t4_count",   32'(count), 32'd2);
        check("t4_err_hold", 32'(err),  32'd1);

        // 5: pop coincident with a push on the CAPT cycle
        n_en = 1'b0;
        @(negedge clk);
        n_rd = 1'b0;
        @(negedge clk);
        n_rd = 1'b1;
        n_en = 1'b1;
        check("t5_count", 32'(count), 32'd2);
        check("t5_dout_x", 32'(dout), 32'(CH_X));
        repeat (3) @(negedge clk);
        check("t5_err_sticky", 32'(err), 32'd1);
        n_rd = 1'b0;
        @(negedge clk);
        n_rd = 1'b1;
        check("t5_dout_a", 32'(dout), 32'(CH_A));
        n_rd = 1'b0;
        @(negedge clk);
        n_rd = 1'b1;
        check("t5_empty", 32'(empty), 32'd1);

        // 6: reset during the chip-select pulse
        n_en = 1'b0;
        for (k = 0; k < 20 && src_cs_n !== 1'b0; k++) @(negedge clk);
        check("t6_in_adv", 32'(src_cs_n), 32'd0);
        n_rst = 1'b0;
        #1;
        check("t6_cs_n",  32'(src_cs_n), 32'd1);
        check("t6_empty", 32'(empty),    32'd1);
        check("t6_count", 32'(count),    32'd0);
        check("t6_err",   32'(err),      32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (k = 0; k < 20 && empty !== 1'b0; k++) @(negedge clk);
        check("t6_first_a", 32'(dout), 32'(CH_A));
        check("t6_err_clr", 32'(err),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
